button_debounce_fsm: RTL and testbench

- Upstream conditioning stage for the board push-button that feeds the LED blink FSM reset/control input.
- Synchronises the raw pin into clk, rejects contact bounce with a counter-qualified Moore FSM, and emits a clean level plus single-cycle press/release pulses.
- The downstream blink logic consumes `btn_level` or `press_pulse` instead of the raw, bouncing pin.

---
 rtl/button_debounce_fsm.sv | 166 ++++++++++++++++
 tb/tb_button_debounce_fsm.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/button_debounce_fsm.sv
// Push-button conditioner: two-flop synchroniser, counter-qualified Moore debounce FSM,
// registered level plus press/release pulses. Define LONG_PRESS_EN to add the long-press pulse.
module button_debounce_fsm #(
    parameter int unsigned DEBOUNCE_CYCLES   = 270000,
    parameter bit          ACTIVE_HIGH       = 1'b1,
    parameter int unsigned LONG_PRESS_CYCLES = 27000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    localparam int unsigned    CNT_W     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Raw pin level that normalises to "not pressed"
    localparam logic           SYNC_IDLE = ~ACTIVE_HIGH;

    if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES < 2) begin : g_param_check
        $error("button_debounce_fsm: DEBOUNCE_CYCLES and LONG_PRESS_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'b00,
        ST_PRESS_WAIT   = 2'b01,
        ST_PRESSED      = 2'b10,
        ST_RELEASE_WAIT = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             btn_act;

    assign btn_act = ACTIVE_HIGH ? s2_q : ~s2_q;

    // Synchroniser, debounce FSM and registered outputs
    always_comb begin
        s1_d      = btn_raw;
        s2_d      = s1_q;
        state_d   = state_q;
        count_d   = count_q;
        press_d   = 1'b0;
        release_d = 1'b0;

        case (state_q)
            ST_RELEASED: begin
                if (btn_act) begin
                    state_d = ST_PRESS_WAIT;
                    count_d = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!btn_act) begin
                    state_d = ST_RELEASED;
                    count_d = '0;
                end else if (count_q == CNT_LAST) begin
                    state_d = ST_PRESSED;
                    count_d = '0;
                    press_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            ST_PRESSED: begin
                if (!btn_act) begin
                    state_d = ST_RELEASE_WAIT;
                    count_d = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (btn_act) begin
                    state_d = ST_PRESSED;
                    count_d = '0;
                end else if (count_q == CNT_LAST) begin
                    state_d   = ST_RELEASED;
                    count_d   = '0;
                    release_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RELEASED;
                count_d = '0;
            end
        endcase

        level_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q      <= SYNC_IDLE;
            s2_q      <= SYNC_IDLE;
            state_q   <= ST_RELEASED;
            count_q   <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            state_q   <= state_d;
            count_q   <= count_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

`ifdef LONG_PRESS_EN
    localparam int unsigned       HOLD_W    = $clog2(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_done_q, long_done_d;
    logic              long_q, long_d;

    // Hold timer runs only in PRESSED, freezes across release bounces, one pulse per press
    always_comb begin
        hold_d      = hold_q;
        long_done_d = long_done_q;
        long_d      = 1'b0;
        if (state_d == ST_RELEASED) begin
            hold_d      = '0;
            long_done_d = 1'b0;
        end else if (state_q == ST_PRESSED && !long_done_q) begin
            if (hold_q == HOLD_LAST) begin
                long_d      = 1'b1;
                long_done_d = 1'b1;
            end else begin
                hold_d = hold_q + HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_q      <= '0;
            long_done_q <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            long_done_q <= long_done_d;
            long_q      <= long_d;
        end
    end

    assign long_press = long_q;
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce_fsm.sv
// Randomised bench for button_debounce_fsm: both pin polarities driven with the same logical
// button, checked every cycle against a run-length model of the debounce rules.
module tb_button_debounce_fsm;

    localparam int unsigned DB = 4;
    localparam int unsigned LP = 10;

    logic clk = 1'b0;
    logic rst;
    logic btn_raw;
    logic btn_raw_n;

    logic hi_level, hi_press, hi_release, hi_long;
    logic lo_level, lo_press, lo_release, lo_long;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state: two-deep pin delay, accepted level, run of disagreeing samples
    bit m_p1, m_p2, m_lvl;
    int m_run, m_held;
    bit e_press, e_release, e_long;

    always #5 clk = ~clk;

    button_debounce_fsm #(
        .DEBOUNCE_CYCLES  (DB),
        .ACTIVE_HIGH      (1'b1),
        .LONG_PRESS_CYCLES(LP)
    ) u_dut_hi (
        .clk          (clk),
        .rst          (rst),
        .btn_raw      (btn_raw),
        .btn_level    (hi_level),
        .press_pulse  (hi_press),
        .release_pulse(hi_release),
        .long_press   (hi_long)
    );

    button_debounce_fsm #(
        .DEBOUNCE_CYCLES  (DB),
        .ACTIVE_HIGH      (1'b0),
        .LONG_PRESS_CYCLES(LP)
    ) u_dut_lo (
        .clk          (clk),
        .rst          (rst),
        .btn_raw      (btn_raw_n),
        .btn_level    (lo_level),
        .press_pulse  (lo_press),
        .release_pulse(lo_release),
        .long_press   (lo_long)
    );

    task automatic check_bit(input string tag, input logic obs, input logic want);
        n_total++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0b, want %0b", tag, $time, obs, want);
        end
    endtask

    // A change is accepted once DB+1 consecutive synchronised samples disagree with the level
    task automatic model_edge(input logic r, input logic pressed);
        bit x;
        e_press   = 1'b0;
        e_release = 1'b0;
        e_long    = 1'b0;
        if (!r) begin
            m_p1   = 1'b0;
            m_p2   = 1'b0;
            m_lvl  = 1'b0;
            m_run  = 0;
            m_held = 0;
        end else begin
            x    = m_p2;
            m_p2 = m_p1;
            m_p1 = pressed;
            if (m_lvl && m_run == 0 && m_held < int'(LP)) begin
                m_held++;
                if (m_held == int'(LP)) e_long = 1'b1;
            end
            m_run = (x != m_lvl) ? m_run + 1 : 0;
            if (m_run == int'(DB) + 1) begin
                m_lvl = !m_lvl;
                m_run = 0;
                if (m_lvl) begin
                    e_press = 1'b1;
                end else begin
                    e_release = 1'b1;
                    m_held    = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        logic want_long;
`ifdef LONG_PRESS_EN
        want_long = e_long;
`else
        want_long = 1'b0;
`endif
        check_bit("hi_level",   hi_level,   m_lvl);
        check_bit("hi_press",   hi_press,   e_press);
        check_bit("hi_release", hi_release, e_release);
        check_bit("hi_long",    hi_long,    want_long);
        check_bit("hi_excl",    hi_press & hi_release, 1'b0);
        check_bit("lo_level",   lo_level,   m_lvl);
        check_bit("lo_press",   lo_press,   e_press);
        check_bit("lo_release", lo_release, e_release);
        check_bit("lo_long",    lo_long,    want_long);
        check_bit("lo_excl",    lo_press & lo_release, 1'b0);
    endtask

    // One clock: drive on the falling edge, advance the model at the rising edge, check just after
    task automatic step(input logic r, input logic pressed);
        @(negedge clk);
        rst       = r;
        btn_raw   = pressed;
        btn_raw_n = ~pressed;
        @(posedge clk);
        model_edge(r, pressed);
        #1;
        check_all();
    endtask

    initial begin
        bit pat [6];
        int seg_len;
        bit seg_val;
        pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        rst       = 1'b0;
        btn_raw   = 1'b1;
        btn_raw_n = 1'b0;

        // Held button through reset, then re-qualified press and long hold
        repeat (3) step(1'b0, 1'b1);
        repeat (30) step(1'b1, 1'b1);
        repeat (12) step(1'b1, 1'b0);

        // Press bounce never qualifies
        for (int i = 0; i < 20; i++) step(1'b1, pat[i % 6]);
        repeat (10) step(1'b1, 1'b0);

        // Short release glitch while pressed
        repeat (12) step(1'b1, 1'b1);
        repeat (2) step(1'b1, 1'b0);
        repeat (16) step(1'b1, 1'b1);
        repeat (12) step(1'b1, 1'b0);

        // Reset mid-press, button kept held
        repeat (9) step(1'b1, 1'b1);
        repeat (2) step(1'b0, 1'b1);
        repeat (14) step(1'b1, 1'b1);
        repeat (10) step(1'b1, 1'b0);

        // Random segments with occasional reset
        for (int s = 0; s < 150; s++) begin
            seg_len = int'($urandom_range(1, 14));
            seg_val = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) step(1'b0, seg_val);
            for (int k = 0; k < seg_len; k++) step(1'b1, seg_val);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
